// File: rtl/ultrasonic_echo_responder.sv
// HC-SR04 sensor emulator: answers a trigger pulse with a distance-coded echo pulse.
// Optional build macro ECHO_JITTER_EN adds 0..7 us of LFSR jitter to the echo width.
module ultrasonic_echo_responder #(
    parameter int TICK_DIV       = 50,
    parameter int MIN_TRIG_US    = 10,
    parameter int BURST_DELAY_US = 200,
    parameter int US_PER_CM      = 58,
    parameter int TIMEOUT_US     = 38000,
    parameter int HOLDOFF_US     = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trigger,
    input  logic [8:0]  distance_cm,
    input  logic        no_target,
    output logic        echo,
    output logic        busy,
    output logic        trig_err,
    output logic [15:0] meas_count
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_TRIG_HI = 3'd1;
    localparam logic [2:0] S_BURST   = 3'd2;
    localparam logic [2:0] S_ECHO_HI = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;

    logic [2:0]    state;
    logic [PW-1:0] presc;
    logic          tick;
    logic          trig_s1, trig_s2, trig_d;
    logic          trig_rise, trig_fall;
    logic [7:0]    width_cnt;
    logic [15:0]   timer, timer_nx;
    logic [15:0]   w_reg, w_calc;
    logic [17:0]   product;
`ifdef ECHO_JITTER_EN
    logic [7:0]    lfsr;
`endif

    assign tick      = (presc == PW'(TICK_DIV - 1));
    assign trig_rise = trig_s2 & ~trig_d;
    assign trig_fall = ~trig_s2 & trig_d;
    assign timer_nx  = timer + 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            trig_s1 <= 1'b0;
            trig_s2 <= 1'b0;
            trig_d  <= 1'b0;
        end else begin
            presc   <= tick ? '0 : presc + 1'b1;
            trig_s1 <= trigger;
            trig_s2 <= trig_s1;
            trig_d  <= trig_s2;
        end
    end

    // Zero distance still yields a 1 us echo; jitter (if built in) is added before the clamp.
    always_comb begin
        product = (distance_cm == '0) ? 18'd1 : 18'(distance_cm) * 18'(US_PER_CM);
`ifdef ECHO_JITTER_EN
        product = product + 18'(lfsr[2:0]);
`endif
        if (no_target || product > 18'(TIMEOUT_US))
            w_calc = 16'(TIMEOUT_US);
        else
            w_calc = product[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            echo       <= 1'b0;
            busy       <= 1'b0;
            trig_err   <= 1'b0;
            meas_count <= '0;
            width_cnt  <= '0;
            timer      <= '0;
            w_reg      <= '0;
`ifdef ECHO_JITTER_EN
            lfsr       <= 8'hA5;
`endif
        end else begin
            trig_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (trig_rise) begin
                        state     <= S_TRIG_HI;
                        width_cnt <= '0;
                        busy      <= 1'b1;
                    end
                end
                S_TRIG_HI: begin
                    if (trig_fall) begin
                        if (width_cnt >= 8'(MIN_TRIG_US)) begin
                            w_reg <= w_calc;
                            timer <= '0;
                            state <= S_BURST;
`ifdef ECHO_JITTER_EN
                            lfsr  <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
`endif
                        end else begin
                            trig_err <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end else if (tick && trig_s2 && width_cnt != '1) begin
                        width_cnt <= width_cnt + 8'd1;
                    end
                end
                S_BURST: begin
                    if (tick) begin
                        if (timer_nx == 16'(BURST_DELAY_US)) begin
                            echo  <= 1'b1;
                            timer <= '0;
                            state <= S_ECHO_HI;
                        end else begin
                            timer <= timer_nx;
                        end
                    end
                end
                S_ECHO_HI: begin
                    if (tick) begin
                        if (timer_nx == w_reg) begin
                            echo       <= 1'b0;
                            meas_count <= meas_count + 16'd1;
                            timer      <= '0;
                            state      <= S_HOLDOFF;
                        end else begin
                            timer <= timer_nx;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (tick) begin
                        if (timer_nx == 16'(HOLDOFF_US)) begin
                            timer <= '0;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            timer <= timer_nx;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    echo  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Scoreboard bench for ultrasonic_echo_responder with shortened tick, timeout and holdoff.
module tb_ultrasonic_echo_responder;

    localparam int TD  = 2;
    localparam int HO  = 100;
    localparam int TO  = 1450;
    localparam int BD  = 200;
    localparam int MT  = 10;
    localparam int UPC = 58;

    logic        clk = 1'b0;
    logic        rst;
    logic        trigger;
    logic [8:0]  distance_cm;
    logic        no_target;
    logic        echo, busy, trig_err;
    logic [15:0] meas_count;

    ultrasonic_echo_responder #(
        .TICK_DIV(TD), .MIN_TRIG_US(MT), .BURST_DELAY_US(BD),
        .US_PER_CM(UPC), .TIMEOUT_US(TO), .HOLDOFF_US(HO)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .distance_cm(distance_cm),
        .no_target(no_target), .echo(echo), .busy(busy), .trig_err(trig_err),
        .meas_count(meas_count)
    );

    always #10 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned width_clk;
        int unsigned fall_cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int unsigned err_seen = 0, err_exp = 0, cnt_exp = 0;
    int unsigned last_fall = 0, rise_cyc = 0;
    bit          echo_q = 1'b0;
    bit          abort_pending = 1'b0;
    exp_t        mon_e;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d (cyc %0d)", name, act, lo, hi, cyc);
        end
    endtask

    // Reference echo width in ticks, straight from the distance rules.
    function automatic int unsigned model_w(input int unsigned d, input bit nt);
        int unsigned w;
        if (nt) return TO;
        w = (d == 0) ? 1 : d * UPC;
        if (w > TO) w = TO;
        return w;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            if (trig_err) err_seen++;
            if (echo && !echo_q) begin
                rise_cyc = cyc;
                check("busy_at_echo_rise", busy, 1);
                if (sb.size() == 0) check("unexpected_echo", 1, 0);
                else check_rng("burst_delay", cyc - sb[0].fall_cyc, BD*TD - TD, BD*TD + TD + 4);
            end
            if (!echo && echo_q) begin
                if (sb.size() == 0) begin
                    check("echo_without_expectation", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("echo_cut_by_reset", rst, abort_pending);
                    if (!abort_pending) begin
                        check("echo_width", cyc - rise_cyc, mon_e.width_clk);
                        last_fall = cyc;
                    end
                    abort_pending = 1'b0;
                end
            end
            echo_q = echo;
        end
    end

    task automatic wait_echo(input bit v);
        int n = 0;
        while (echo != v && n < 10000) begin
            @(negedge clk);
            n++;
        end
        if (echo != v) check("echo_wait_timeout", echo, v);
    endtask

    task automatic pulse(input int unsigned us);
        @(negedge clk);
        trigger = 1'b1;
        repeat (us * TD) @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic start(input int unsigned d, input bit nt, input int unsigned us);
        exp_t e;
        distance_cm = 9'(d);
        no_target   = nt;
        @(negedge clk);
        trigger = 1'b1;
        repeat (us * TD) @(negedge clk);
        check("busy_during_trigger", busy, 1);
        trigger = 1'b0;
        if (us >= MT) begin
            e.width_clk = model_w(d, nt) * TD;
            e.fall_cyc  = cyc;
            sb.push_back(e);
            cnt_exp++;
        end else begin
            err_exp++;
        end
    endtask

    task automatic finish_meas(input bit accepted);
        int n = 0;
        repeat (10) @(negedge clk);
        distance_cm = 9'($urandom_range(0, 511));
        no_target   = 1'($urandom_range(0, 1));
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", busy, 0);
        if (accepted) check("holdoff_len", cyc - last_fall, HO * TD);
        check("echo_idle", echo, 0);
        check("meas_count", meas_count, cnt_exp & 16'hFFFF);
        check("trig_err_pulses", err_seen, err_exp);
    endtask

    task automatic measure(input int unsigned d, input bit nt, input int unsigned us);
        start(d, nt, us);
        finish_meas(us >= MT);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        trigger = 1'b0;
        distance_cm = '0;
        no_target = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_echo", echo, 0);
        check("reset_busy", busy, 0);
        check("reset_trig_err", trig_err, 0);
        check("reset_meas_count", meas_count, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        measure(10, 0, 12);
        measure(10, 0, 5);
        measure(10, 1, 12);
        measure(0, 0, 12);
        measure(25, 0, 12);
        measure(24, 0, 12);

        // Retriggers during echo and during holdoff must be ignored.
        start(10, 0, 12);
        wait_echo(1);
        repeat (50) @(negedge clk);
        pulse(12);
        wait_echo(0);
        repeat (20) @(negedge clk);
        pulse(12);
        finish_meas(1);

        // Reset in the middle of the echo.
        start(10, 0, 12);
        wait_echo(1);
        repeat (100) @(negedge clk);
        abort_pending = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_echo_drop", echo, 0);
        check("rst_busy", busy, 0);
        check("rst_meas_count", meas_count, 0);
        cnt_exp = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        measure(10, 0, 12);

        measure(10, 0, 12);
        measure(300, 0, 12);

        for (int i = 0; i < 6; i++) begin
            int unsigned d, us;
            bit nt;
            d  = $urandom_range(0, 30);
            nt = ($urandom_range(0, 5) == 0);
            us = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 7) : $urandom_range(11, 20);
            measure(d, nt, us);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
